mem_burst_responder: RTL and testbench

//  Memory-side responder for the rd_/wr_ burst request interface used by the video processing masters.

---
 rtl/mem_burst_responder.sv | 146 ++++++++++++++
 tb/tb_mem_burst_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_responder.sv
// mem_burst_responder: memory-side responder for the rd_/wr_ burst request
// interface. Serves one read or write burst at a time from an internal
// single-port synchronous RAM, with per-beat ready strobes and a one-cycle
// finish pulse per burst.
module mem_burst_responder #(
   parameter int MEM_DATA_LEN  = 64,
   parameter int ADDR_LEN      = 32,
   parameter int MEM_ADDR_BITS = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rd_valid,
   output logic                    rd_ready,
   input  logic [9:0]              rd_burst_len,
   input  logic [ADDR_LEN-1:0]     rd_addr,
   output logic [MEM_DATA_LEN-1:0] rd_data,
   output logic                    rd_burst_finish,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [9:0]              wr_burst_len,
   input  logic [ADDR_LEN-1:0]     wr_addr,
   input  logic [MEM_DATA_LEN-1:0] wr_data,
   output logic                    wr_burst_finish,
   input  logic                    stall,
   output logic                    busy,
   output logic                    addr_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_RUN,
      S_RD_DRAIN,
      S_RD_FIN,
      S_WR_RUN,
      S_WR_FIN,
      S_GAP
   } state_t;

   state_t                   state_q, state_d;
   logic [MEM_ADDR_BITS-1:0] idx_q, idx_d;
   logic [9:0]               rem_q, rem_d;
   logic                     rd_ready_q, rd_ready_d;
   logic                     addr_err_q, addr_err_d;
   logic [MEM_DATA_LEN-1:0]  rd_data_q;
   logic                     rd_issue;
   logic                     wr_fire;

   logic [MEM_DATA_LEN-1:0]  mem [0:(2**MEM_ADDR_BITS)-1];

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state, burst bookkeeping and strobe decode.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      rem_d           = rem_q;
      addr_err_d      = addr_err_q;
      rd_issue        = 1'b0;
      wr_fire         = 1'b0;
      wr_ready        = 1'b0;
      rd_burst_finish = 1'b0;
      wr_burst_finish = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rd_valid) begin
               state_d = S_RD_RUN;
               idx_d   = rd_addr[MEM_ADDR_BITS-1:0];
               rem_d   = (rd_burst_len == '0) ? 10'd1 : rd_burst_len;
               if (rd_addr[ADDR_LEN-1:MEM_ADDR_BITS] != '0) addr_err_d = 1'b1;
            end else if (wr_valid) begin
               state_d = S_WR_RUN;
               idx_d   = wr_addr[MEM_ADDR_BITS-1:0];
               rem_d   = (wr_burst_len == '0) ? 10'd1 : wr_burst_len;
               if (wr_addr[ADDR_LEN-1:MEM_ADDR_BITS] != '0) addr_err_d = 1'b1;
            end
         end
         S_RD_RUN: begin
            if (!stall) begin
               rd_issue = 1'b1;
               idx_d    = idx_q + MEM_ADDR_BITS'(1);
               rem_d    = rem_q - 10'd1;
               if (rem_q == 10'd1) state_d = S_RD_DRAIN;
            end
         end
         S_RD_DRAIN: state_d = S_RD_FIN;
         S_RD_FIN: begin
            rd_burst_finish = 1'b1;
            state_d         = S_GAP;
         end
         S_WR_RUN: begin
            wr_ready = !stall;
            if (!stall) begin
               // RAM write is suppressed on a reset edge so an aborted burst
               // does not land a partial beat.
               wr_fire = rst;
               idx_d   = idx_q + MEM_ADDR_BITS'(1);
               rem_d   = rem_q - 10'd1;
               if (rem_q == 10'd1) state_d = S_WR_FIN;
            end
         end
         S_WR_FIN: begin
            wr_burst_finish = 1'b1;
            state_d         = S_GAP;
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      rd_ready_d = rd_issue;
   end

   // Burst index/count, registered read strobe and sticky address error.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q      <= '0;
         rem_q      <= '0;
         rd_ready_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         rd_ready_q <= rd_ready_d;
         addr_err_q <= addr_err_d;
      end
   end

   // RAM read port: data register holds its value between beats.
   always_ff @(posedge clk) begin
      if (!rst)          rd_data_q <= '0;
      else if (rd_issue) rd_data_q <= mem[idx_q];
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[idx_q] <= wr_data;
   end

   assign rd_ready = rd_ready_q;
   assign rd_data  = rd_data_q;
   assign busy     = (state_q != S_IDLE);
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed testbench for mem_burst_responder. Interval n is the clock period
// ending at the n-th edge after the accept edge; outputs are sampled on the
// falling edge inside each interval.
module tb_mem_burst_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rd_valid = 1'b0, rd_ready, rd_burst_finish;
   logic [9:0]  rd_burst_len = '0;
   logic [31:0] rd_addr = '0;
   logic [63:0] rd_data;
   logic        wr_valid = 1'b0, wr_ready, wr_burst_finish;
   logic [9:0]  wr_burst_len = '0;
   logic [31:0] wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        stall = 1'b0, busy, addr_err;

   int          n_tests = 0;
   int          n_fail  = 0;

   int          rdy_cyc [16];
   logic [63:0] rdy_dat [16];
   logic [63:0] wdat    [8];
   int          nrdy, nfin, fin_cyc, idle_cyc;
   bit          overlap;

   mem_burst_responder #(
      .MEM_DATA_LEN (64),
      .ADDR_LEN     (32),
      .MEM_ADDR_BITS(12)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_burst_len   (rd_burst_len),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_burst_finish(rd_burst_finish),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_burst_len   (wr_burst_len),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_burst_finish(wr_burst_finish),
      .stall          (stall),
      .busy           (busy),
      .addr_err       (addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs one burst from IDLE (called just after a rising edge). smask bit n
   // drives stall during interval n. Records ready/finish timing and data.
   task automatic burst(input bit is_rd, input logic [31:0] addr,
                        input logic [9:0] len, input logic [31:0] smask);
      logic rdy, fin;
      nrdy = 0; nfin = 0; fin_cyc = -1; idle_cyc = -1; overlap = 0;
      stall = 1'b0;
      if (is_rd) begin
         rd_valid = 1'b1; rd_addr = addr; rd_burst_len = len;
      end else begin
         wr_valid = 1'b1; wr_addr = addr; wr_burst_len = len; wr_data = wdat[0];
      end
      @(posedge clk); #1;
      stall = smask[1];
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         rdy = is_rd ? rd_ready : wr_ready;
         fin = is_rd ? rd_burst_finish : wr_burst_finish;
         if (rdy) begin
            if (nrdy < 16) begin
               rdy_cyc[nrdy] = n;
               rdy_dat[nrdy] = rd_data;
            end
            nrdy++;
         end
         if (fin) begin
            nfin++;
            if (fin_cyc < 0) fin_cyc = n;
         end
         if (rdy && fin) overlap = 1;
         if (!busy && idle_cyc < 0) idle_cyc = n;
         @(posedge clk); #1;
         if (fin) begin
            if (is_rd) rd_valid = 1'b0;
            else       wr_valid = 1'b0;
         end
         stall = (n < 31) ? smask[n+1] : 1'b0;
         if (!is_rd && nrdy < 8) wr_data = wdat[nrdy];
         if (idle_cyc >= 0) break;
      end
      stall = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int wbeats, wfirst, wfin;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_flags", {rd_ready, rd_burst_finish, wr_ready, wr_burst_finish, busy, addr_err}, 64'd0);
      check("rst_rd_data", rd_data, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // T1: write 4 beats at 0x10
      wdat[0] = 64'hA; wdat[1] = 64'hB; wdat[2] = 64'hC; wdat[3] = 64'hD;
      burst(1'b0, 32'h10, 10'd4, 32'h0);
      check("t1_beats", nrdy, 4);
      check("t1_first", rdy_cyc[0], 1);
      check("t1_last", rdy_cyc[3], 4);
      check("t1_fin_cyc", fin_cyc, 5);
      check("t1_nfin", nfin, 1);
      check("t1_idle", idle_cyc, 7);

      // T2: read back 4 beats
      burst(1'b1, 32'h10, 10'd4, 32'h0);
      check("t2_beats", nrdy, 4);
      check("t2_first", rdy_cyc[0], 2);
      check("t2_last", rdy_cyc[3], 5);
      check("t2_d0", rdy_dat[0], 64'hA);
      check("t2_d1", rdy_dat[1], 64'hB);
      check("t2_d2", rdy_dat[2], 64'hC);
      check("t2_d3", rdy_dat[3], 64'hD);
      check("t2_fin_cyc", fin_cyc, 6);
      check("t2_overlap", overlap, 0);
      check("t2_idle", idle_cyc, 8);

      // T3: read 3 beats, stall over intervals 2..3 (second beat's issue)
      burst(1'b1, 32'h10, 10'd3, 32'h0000_000C);
      check("t3_beats", nrdy, 3);
      check("t3_c0", rdy_cyc[0], 2);
      check("t3_c1", rdy_cyc[1], 5);
      check("t3_c2", rdy_cyc[2], 6);
      check("t3_d0", rdy_dat[0], 64'hA);
      check("t3_d1", rdy_dat[1], 64'hB);
      check("t3_d2", rdy_dat[2], 64'hC);
      check("t3_fin_cyc", fin_cyc, 7);

      // T4: both valid, read wins; len=0 gives one beat each
      wr_valid = 1'b1; wr_addr = 32'h20; wr_burst_len = 10'd0; wr_data = 64'h55;
      burst(1'b1, 32'h11, 10'd0, 32'h0);
      check("t4_rd_beats", nrdy, 1);
      check("t4_rd_data", rdy_dat[0], 64'hB);
      check("t4_rd_fin", fin_cyc, 3);
      check("t4_rd_idle", idle_cyc, 5);
      wbeats = 0; wfirst = -1; wfin = -1;
      for (int n = 6; n <= 15; n++) begin
         @(negedge clk);
         if (wr_ready) begin
            wbeats++;
            if (wfirst < 0) wfirst = n;
         end
         if (wr_burst_finish && wfin < 0) wfin = n;
         @(posedge clk); #1;
         if (wfin >= 0) wr_valid = 1'b0;
      end
      check("t4_wr_beats", wbeats, 1);
      check("t4_wr_first", wfirst, 6);
      check("t4_wr_fin", wfin, 7);
      burst(1'b1, 32'h20, 10'd1, 32'h0);
      check("t4_wr_mem", rdy_dat[0], 64'h55);
      check("t4_no_err", addr_err, 1'b0);

      // T5: out-of-range write wraps over the RAM top
      wdat[0] = 64'h71; wdat[1] = 64'h72; wdat[2] = 64'h73;
      burst(1'b0, 32'h1FFF, 10'd3, 32'h0);
      check("t5_beats", nrdy, 3);
      check("t5_err", addr_err, 1'b1);
      burst(1'b1, 32'hFFF, 10'd3, 32'h0);
      check("t5_top", rdy_dat[0], 64'h71);
      check("t5_w0", rdy_dat[1], 64'h72);
      check("t5_w1", rdy_dat[2], 64'h73);
      check("t5_sticky", addr_err, 1'b1);

      // T6: reset during read beat 2
      rd_valid = 1'b1; rd_addr = 32'h10; rd_burst_len = 10'd4;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_pre_rdy", rd_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; rd_valid = 1'b0;
      @(negedge clk);
      check("t6_flags", {rd_ready, rd_burst_finish, wr_ready, wr_burst_finish, busy, addr_err}, 64'd0);
      check("t6_rd_data", rd_data, 64'd0);
      nfin = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (rd_burst_finish || busy) nfin++;
      end
      check("t6_no_fin", nfin, 0);
      @(posedge clk); #1;
      burst(1'b1, 32'h10, 10'd4, 32'h0);
      check("t6_beats", nrdy, 4);
      check("t6_d0", rdy_dat[0], 64'hA);
      check("t6_d3", rdy_dat[3], 64'hD);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
